// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic datapath types, constants and helpers
// Contents: state_t (divider FSM states), clog2() for counter sizing,
// DIV0_QUOT (quotient reported on divide-by-zero, slice to the operand width).
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_WIDTH = 16;

  localparam logic [MAX_WIDTH-1:0] DIV0_QUOT = {MAX_WIDTH{1'b1}};

  // Ceiling log2; the step counter must hold the value WIDTH, so callers pass WIDTH+1.
  function automatic int clog2(input int value);
    int bits;
    int v;
    bits = 0;
    v = value - 1;
    while (v > 0) begin
      bits = bits + 1;
      v = v >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/array_restoring_divider_if.sv
// rtl/array_restoring_divider_if.sv - start/busy/done handshake bundle of the divider
// Signals: start, A, B (controller -> divider); busy, done, Q, R, div_by_zero (divider -> controller).
// Modports: master (controller side), slave (divider side).
interface array_restoring_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             div_by_zero;

  modport master (
    output start, A, B,
    input  busy, done, Q, R, div_by_zero
  );

  modport slave (
    input  start, A, B,
    output busy, done, Q, R, div_by_zero
  );
endinterface

// File: rtl/array_restoring_divider_step.sv
// rtl/array_restoring_divider_step.sv - one combinational restoring-division step
// Inputs: rem (WIDTH+1 partial remainder), dvd_msb (next dividend bit), divisor.
// Outputs: rem_out (updated partial remainder), q_bit (quotient bit produced by this step).
module restoring_div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);
  logic [WIDTH:0] rem_next;
  logic [WIDTH:0] diff;

  assign rem_next = {rem[WIDTH-1:0], dvd_msb};
  assign diff     = rem_next - {1'b0, divisor};
  // Restore (keep rem_next) when the trial subtraction would go negative.
  assign q_bit    = (rem_next >= {1'b0, divisor});
  assign rem_out  = q_bit ? diff : rem_next;
endmodule

// File: rtl/array_restoring_divider.sv
// rtl/array_restoring_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
// Ports: clk, rst_n (synchronous, active-low); bus (slave side of array_restoring_divider_if):
// start/A/B in, busy/done/Q/R/div_by_zero out. Q = A / B, R = A % B after WIDTH RUN cycles.
module array_restoring_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  array_restoring_divider_if.slave    bus
);
  localparam int CW = clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   rem_step;
  logic             q_bit;
  logic [WIDTH-1:0] dvd_step;

  restoring_div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .dvd_msb (dvd[WIDTH-1]),
    .divisor (divisor),
    .rem_out (rem_step),
    .q_bit   (q_bit)
  );

  // Dividend bits leave at the MSB while quotient bits enter at the LSB,
  // so after WIDTH steps the dividend register holds the quotient.
  assign dvd_step = {dvd[WIDTH-2:0], q_bit};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      dvd             <= '0;
      divisor         <= '0;
      rem             <= '0;
      cnt             <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.Q           <= '0;
      bus.R           <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          // start is deliberately not looked at here: an operation in flight is never disturbed.
          dvd <= dvd_step;
          rem <= rem_step;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.Q    <= dvd_step;
            bus.R    <= rem_step[WIDTH-1:0];
          end
        end
        default: begin
          // IDLE and DONE both accept a new operation; accepting in DONE gives back-to-back issue.
          if (bus.start) begin
            dvd     <= bus.A;
            divisor <= bus.B;
            rem     <= '0;
            cnt     <= CW'(WIDTH);
            if (bus.B == '0) begin
              // Divide-by-zero skips RUN entirely and reports immediately.
              state           <= DONE;
              bus.busy        <= 1'b0;
              bus.done        <= 1'b1;
              bus.Q           <= DIV0_QUOT[WIDTH-1:0];
              bus.R           <= bus.A;
              bus.div_by_zero <= 1'b1;
            end else begin
              // Q and R keep the previous result until the new one lands.
              state           <= RUN;
              bus.busy        <= 1'b1;
              bus.done        <= 1'b0;
              bus.div_by_zero <= 1'b0;
            end
          end else begin
            state    <= IDLE;
            bus.done <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_array_restoring_divider.sv
// tb/tb_array_restoring_divider.sv - self-checking bench for array_restoring_divider (WIDTH 4 and 8)
module tb_array_restoring_divider;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  array_restoring_divider_if #(.WIDTH(4)) f4 ();
  array_restoring_divider_if #(.WIDTH(8)) f8 ();

  array_restoring_divider #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (f4.slave)
  );

  array_restoring_divider #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (f8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          lat;
    int          busy_cyc;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division, with the divide-by-zero rule.
  task automatic model(input int w, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r, output logic dz);
    logic [15:0] ones;
    ones = 16'hFFFF >> (16 - w);
    if (b == 0) begin
      q = ones; r = a; dz = 1'b1;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endtask

  function automatic logic cur_done(input bit w8);
    return w8 ? f8.done : f4.done;
  endfunction

  function automatic logic cur_busy(input bit w8);
    return w8 ? f8.busy : f4.busy;
  endfunction

  // Called at a negedge; drives start for one edge and waits (bounded) for done.
  // edges counts clock edges from the accepting edge up to and including the one raising done.
  task automatic run_op(input bit w8, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] q, output logic [15:0] r, output logic dz,
                        output int edges, output int busy_cyc);
    edges = 0;
    busy_cyc = 0;
    if (w8) begin
      f8.start = 1'b1; f8.A = a[7:0]; f8.B = b[7:0];
    end else begin
      f4.start = 1'b1; f4.A = a[3:0]; f4.B = b[3:0];
    end
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      f4.start = 1'b0;
      f8.start = 1'b0;
      if (cur_busy(w8)) busy_cyc++;
      if (cur_done(w8)) break;
    end
    q  = w8 ? {8'd0, f8.Q} : {12'd0, f4.Q};
    r  = w8 ? {8'd0, f8.R} : {12'd0, f4.R};
    dz = w8 ? f8.div_by_zero : f4.div_by_zero;
  endtask

  logic [15:0] q, r, eq, er;
  logic        dz, edz;
  int          edges, bc;
  logic [15:0] a, b;

  initial begin
    checks = 0;
    errors = 0;
    f4.start = 1'b0; f4.A = '0; f4.B = '0;
    f8.start = 1'b0; f8.A = '0; f8.B = '0;

    vt[0] = '{16'd13, 16'd4,  16'd3,  16'd1,  1'b0, 5, 4};
    vt[1] = '{16'd15, 16'd1,  16'd15, 16'd0,  1'b0, 5, 4};
    vt[2] = '{16'd7,  16'd9,  16'd0,  16'd7,  1'b0, 5, 4};
    vt[3] = '{16'd9,  16'd0,  16'd15, 16'd9,  1'b1, 1, 0};
    vt[4] = '{16'd6,  16'd3,  16'd2,  16'd0,  1'b0, 5, 4};
    vt[5] = '{16'd0,  16'd5,  16'd0,  16'd0,  1'b0, 5, 4};
    vt[6] = '{16'd15, 16'd15, 16'd1,  16'd0,  1'b0, 5, 4};
    vt[7] = '{16'd0,  16'd0,  16'd15, 16'd0,  1'b1, 1, 0};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", f4.busy, 0);
    chk("reset_done", f4.done, 0);
    chk("reset_q", f4.Q, 0);
    chk("reset_r", f4.R, 0);
    chk("reset_dz", f4.div_by_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table, each op started from IDLE.
    for (int i = 0; i < 8; i++) begin
      run_op(1'b0, vt[i].a, vt[i].b, q, r, dz, edges, bc);
      chk($sformatf("tbl%0d_q", i), q, vt[i].q);
      chk($sformatf("tbl%0d_r", i), r, vt[i].r);
      chk($sformatf("tbl%0d_dz", i), dz, vt[i].dz);
      chk($sformatf("tbl%0d_latency", i), edges, vt[i].lat);
      chk($sformatf("tbl%0d_busy_cycles", i), bc, vt[i].busy_cyc);
      @(negedge clk);
      chk($sformatf("tbl%0d_done_pulse", i), f4.done, 0);
      chk($sformatf("tbl%0d_q_hold_idle", i), f4.Q, vt[i].q);
    end

    // Back-to-back: second start issued in the DONE cycle of the first.
    run_op(1'b0, 16'd15, 16'd1, q, r, dz, edges, bc);
    chk("b2b_first_q", q, 15);
    chk("b2b_first_r", r, 0);
    run_op(1'b0, 16'd7, 16'd9, q, r, dz, edges, bc);
    chk("b2b_second_q", q, 0);
    chk("b2b_second_r", r, 7);
    chk("b2b_second_latency", edges, 5);
    chk("b2b_second_busy", bc, 4);

    // Divide by zero then a normal op clears the flag.
    @(negedge clk);
    run_op(1'b0, 16'd9, 16'd0, q, r, dz, edges, bc);
    chk("dz_latency", edges, 1);
    chk("dz_busy", bc, 0);
    chk("dz_flag", dz, 1);
    @(negedge clk);
    run_op(1'b0, 16'd6, 16'd3, q, r, dz, edges, bc);
    chk("after_dz_flag", dz, 0);
    chk("after_dz_q", q, 2);

    // Start pulsed on the 2nd RUN cycle must be ignored.
    @(negedge clk);
    f4.start = 1'b1; f4.A = 4'd12; f4.B = 4'd5;
    edges = 0; bc = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      f4.start = 1'b0;
      if (f4.busy) bc++;
      if (edges == 2) begin
        chk("ign_q_held_during_run", f4.Q, 2);
        chk("ign_dz_cleared", f4.div_by_zero, 0);
        f4.start = 1'b1; f4.A = 4'd1; f4.B = 4'd1;
      end
      if (f4.done) break;
    end
    chk("ign_q", f4.Q, 2);
    chk("ign_r", f4.R, 2);
    chk("ign_latency", edges, 5);
    chk("ign_busy", bc, 4);

    // Reset during the 3rd RUN cycle aborts the operation.
    @(negedge clk);
    f4.start = 1'b1; f4.A = 4'd14; f4.B = 4'd3;
    edges = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      f4.start = 1'b0;
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_busy", f4.busy, 0);
    chk("rst_mid_done", f4.done, 0);
    chk("rst_mid_q", f4.Q, 0);
    chk("rst_mid_r", f4.R, 0);
    chk("rst_mid_dz", f4.div_by_zero, 0);
    bc = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (f4.done || f4.busy) bc++;
    end
    chk("rst_mid_no_done", bc, 0);
    run_op(1'b0, 16'd14, 16'd3, q, r, dz, edges, bc);
    chk("rst_after_q", q, 4);
    chk("rst_after_r", r, 2);

    // Exhaustive WIDTH=4 sweep.
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        a = 16'(ai); b = 16'(bi);
        @(negedge clk);
        run_op(1'b0, a, b, q, r, dz, edges, bc);
        model(4, a, b, eq, er, edz);
        chk($sformatf("sweep4_%0d_%0d", ai, bi), {q, r, 15'd0, dz}, {eq, er, 15'd0, edz});
        if (b != 0) chk($sformatf("sweep4_inv_%0d_%0d", ai, bi), (32'(q) * 32'(b) + 32'(r) == 32'(a)) && (r < b), 1);
        chk($sformatf("sweep4_lat_%0d_%0d", ai, bi), edges, (b == 0) ? 1 : 5);
      end
    end

    // Random WIDTH=8 pairs, some issued back-to-back.
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom_range(0, 255));
      b = 16'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      run_op(1'b1, a, b, q, r, dz, edges, bc);
      model(8, a, b, eq, er, edz);
      chk($sformatf("rand8_%0d_%0d", a, b), {q, r, 15'd0, dz}, {eq, er, 15'd0, edz});
      if (b != 0) chk($sformatf("rand8_inv_%0d_%0d", a, b), (32'(q) * 32'(b) + 32'(r) == 32'(a)) && (r < b), 1);
      chk($sformatf("rand8_lat_%0d_%0d", a, b), edges, (b == 0) ? 1 : 9);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
